// File: rtl/riscv_single_cycle.sv
// riscv_single_cycle: RV32I-subset core that fetches, decodes, executes and retires one instruction per clock.
// Instruction ROM, 32x32 register file and word data RAM are all internal; only clk/reset are ports.
module riscv_single_cycle #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input logic clk,
    input logic reset
);
    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);
    localparam logic [31:0] NOP = 32'h00000013;

    logic [31:0] imem [IMEM_WORDS] = '{
        0: 32'h00500093,
        1: 32'h00A00113,
        2: 32'h002081B3,
        3: 32'h40110233,
        4: 32'h00302023,
        5: 32'h00002283,
        6: 32'h00120463,
        7: 32'h00100313,
        8: 32'h0000006F,
        default: NOP
    };

    logic [31:0] pc;
    logic [31:0] regfile [32];
    logic [31:0] dmem [DMEM_WORDS];

    logic [31:0] w_instr, w_rs1_val, w_rs2_val, w_op_b, w_alu, w_wdata;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_pc_plus4, w_pc_next;
    logic [6:0]  w_opcode, w_funct7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3, w_alu_f3;
    logic        w_r_ok, w_i_ok, w_lw, w_sw, w_br, w_jal, w_taken, w_we;

    assign w_instr = imem[pc[IW+1:2]];
    assign {w_funct7, w_rs2, w_rs1, w_funct3, w_rd, w_opcode} = w_instr;
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : regfile[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : regfile[w_rs2];

    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

    // Anything outside the supported subset decodes to no write and falls through to pc+4
    assign w_r_ok = (w_opcode == 7'h33) &&
                    ((w_funct7 == 7'h00 && w_funct3 != 3'd3) || (w_funct7 == 7'h20 && w_funct3 == 3'd0));
    assign w_i_ok = (w_opcode == 7'h13) && w_funct3 != 3'd1 && w_funct3 != 3'd3 && w_funct3 != 3'd5;
    assign w_lw   = (w_opcode == 7'h03) && w_funct3 == 3'd2;
    assign w_sw   = (w_opcode == 7'h23) && w_funct3 == 3'd2;
    assign w_br   = (w_opcode == 7'h63) && w_funct3[2:1] == 2'b00;
    assign w_jal  = (w_opcode == 7'h6F);

    assign w_op_b   = w_r_ok ? w_rs2_val : w_sw ? w_imm_s : w_imm_i;
    assign w_alu_f3 = (w_lw || w_sw) ? 3'd0 : w_funct3;

    always_comb begin
        case (w_alu_f3)
            3'd0:    w_alu = (w_r_ok && w_funct7[5]) ? w_rs1_val - w_op_b : w_rs1_val + w_op_b;
            3'd1:    w_alu = w_rs1_val << w_op_b[4:0];
            3'd2:    w_alu = {31'd0, $signed(w_rs1_val) < $signed(w_op_b)};
            3'd4:    w_alu = w_rs1_val ^ w_op_b;
            3'd5:    w_alu = w_rs1_val >> w_op_b[4:0];
            3'd6:    w_alu = w_rs1_val | w_op_b;
            3'd7:    w_alu = w_rs1_val & w_op_b;
            default: w_alu = 32'd0;
        endcase
    end

    // funct3[0] selects bne, which inverts the equality result
    assign w_taken    = w_br && ((w_rs1_val == w_rs2_val) ^ w_funct3[0]);
    assign w_pc_plus4 = pc + 32'd4;
    assign w_pc_next  = w_taken ? pc + w_imm_b : w_jal ? pc + w_imm_j : w_pc_plus4;
    assign w_we       = (w_r_ok || w_i_ok || w_lw || w_jal) && w_rd != 5'd0;
    assign w_wdata    = w_jal ? w_pc_plus4 : w_lw ? dmem[w_alu[DW+1:2]] : w_alu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++) regfile[i] <= 32'd0;
            for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= 32'd0;
        end else begin
            pc <= w_pc_next;
            if (w_we) regfile[w_rd] <= w_wdata;
            if (w_sw) dmem[w_alu[DW+1:2]] <= w_rs2_val;
        end
    end
endmodule

// File: tb/tb_riscv_single_cycle.sv
// tb_riscv_single_cycle: directed checks of the built-in program plus random programs against an ISA-level model.
module tb_riscv_single_cycle;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    logic [31:0] m_imem [64];
    logic [31:0] m_x [32];
    logic [31:0] m_mem [64];
    logic [31:0] m_pc;

    riscv_single_cycle dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [31:0] a, b, c, d, e;
        a = f7; b = rs2; c = rs1; d = f3; e = rd;
        return {a[6:0], b[4:0], c[4:0], d[2:0], e[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] im, c, d, e, o;
        im = imm; c = rs1; d = f3; e = rd; o = op;
        return {im[11:0], c[4:0], d[2:0], e[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [31:0] im, b, c;
        im = imm; b = rs2; c = rs1;
        return {im[11:5], b[4:0], c[4:0], 3'b010, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] im, b, c, d;
        im = imm; b = rs2; c = rs1; d = f3;
        return {im[12], im[10:5], b[4:0], c[4:0], d[2:0], im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] im, e;
        im = imm; e = rd;
        return {im[20], im[10:1], im[11], im[19:12], e[4:0], 7'h6F};
    endfunction

    function automatic logic [31:0] rand_instr();
        int r_f7 [8] = '{0, 32, 0, 0, 0, 0, 0, 0};
        int r_f3 [8] = '{0, 0, 7, 6, 4, 2, 1, 5};
        int i_f3 [5] = '{0, 7, 6, 4, 2};
        int k   = int'($urandom_range(0, 9));
        int rd  = int'($urandom_range(0, 7));
        int rs1 = int'($urandom_range(0, 7));
        int rs2 = int'($urandom_range(0, 7));
        int imm = int'($urandom_range(0, 4095)) - 2048;
        int s   = int'($urandom_range(0, 7));
        case (k)
            0: return enc_r(r_f7[s], rs2, rs1, r_f3[s], rd);
            1: return enc_i(imm, rs1, i_f3[s % 5], rd, 7'h13);
            2: return enc_i(imm, rs1, 2, rd, 7'h03);
            3: return enc_s(imm, rs2, rs1);
            4: return enc_b((int'($urandom_range(0, 8)) - 4) * 4, rs2, rs1, int'($urandom_range(0, 1)));
            5: return enc_j((int'($urandom_range(0, 16)) - 8) * 4, rd);
            6: case (s % 5)
                   0: return enc_r(32, rs2, rs1, 5, rd);
                   1: return enc_i(imm, rs1, 3, rd, 7'h13);
                   2: return enc_i(imm, rs1, 1, rd, 7'h13);
                   3: return enc_i(imm, rs1, 0, rd, 7'h37);
                   default: return enc_b(8, rs2, rs1, 4);
               endcase
            default: return enc_i(imm, 0, 0, rd, 7'h13);
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
        for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
    endtask

    // Architectural step: read operands, compute the mnemonic's result, then commit rd, memory and pc
    task automatic model_step(output int rd_o);
        logic [31:0] ins, a, b, ii, is, ib, ij, res, nxt, addr;
        logic [6:0] op, f7;
        logic [2:0] f3;
        int rd;
        bit wr;
        ins = m_imem[m_pc[7:2]];
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; rd = int'(ins[11:7]);
        a = m_x[ins[19:15]]; b = m_x[ins[24:20]];
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        wr = 1'b0; res = 32'd0; nxt = m_pc + 4;
        case (op)
            7'h33: begin
                wr = 1'b1;
                case ({f7, f3})
                    {7'h00, 3'd0}: res = a + b;
                    {7'h20, 3'd0}: res = a - b;
                    {7'h00, 3'd7}: res = a & b;
                    {7'h00, 3'd6}: res = a | b;
                    {7'h00, 3'd4}: res = a ^ b;
                    {7'h00, 3'd2}: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    {7'h00, 3'd1}: res = a << b[4:0];
                    {7'h00, 3'd5}: res = a >> b[4:0];
                    default: wr = 1'b0;
                endcase
            end
            7'h13: begin
                wr = 1'b1;
                case (f3)
                    3'd0: res = a + ii;
                    3'd7: res = a & ii;
                    3'd6: res = a | ii;
                    3'd4: res = a ^ ii;
                    3'd2: res = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
                    default: wr = 1'b0;
                endcase
            end
            7'h03: if (f3 == 3'd2) begin addr = a + ii; res = m_mem[addr[7:2]]; wr = 1'b1; end
            7'h23: if (f3 == 3'd2) begin addr = a + is; m_mem[addr[7:2]] = b; end
            7'h63: if ((f3 == 3'd0 && a == b) || (f3 == 3'd1 && a != b)) nxt = m_pc + ib;
            7'h6F: begin res = m_pc + 4; wr = 1'b1; nxt = m_pc + ij; end
            default: ;
        endcase
        if (wr && rd != 0) m_x[rd] = res;
        m_pc = nxt;
        rd_o = rd;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc [10] = '{4, 8, 12, 16, 20, 24, 32, 32, 32, 32};
        logic [31:0] exp_x [6] = '{5, 10, 15, 5, 15, 0};
        int rd;
        #12;
        check("rst_pc", dut.pc, 32'd0);
        for (int i = 1; i <= 6; i++) check($sformatf("rst_x%0d", i), dut.regfile[i], 32'd0);
        #8 reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            run_edges(1);
            check($sformatf("pc_seq%0d", k), dut.pc, exp_pc[k]);
        end
        for (int i = 0; i < 6; i++) check($sformatf("prog_x%0d", i + 1), dut.regfile[i + 1], exp_x[i]);
        check("prog_dmem0", dut.dmem[0], 32'd15);
        run_edges(1);
        check("halt_pc", dut.pc, 32'd32);

        @(negedge clk); #1 reset = 1'b1; #1;
        check("mid_rst_pc", dut.pc, 32'd0);
        check("mid_rst_x3", dut.regfile[3], 32'd0);
        check("mid_rst_dmem0", dut.dmem[0], 32'd0);
        @(negedge clk) reset = 1'b0;
        run_edges(4);
        check("pre_rst_pc", dut.pc, 32'd16);
        #2 reset = 1'b1; #1;
        check("rst16_pc", dut.pc, 32'd0);
        check("rst16_x1", dut.regfile[1], 32'd0);
        @(negedge clk) reset = 1'b0;
        run_edges(10);
        for (int i = 0; i < 6; i++) check($sformatf("rerun_x%0d", i + 1), dut.regfile[i + 1], exp_x[i]);
        check("rerun_dmem0", dut.dmem[0], 32'd15);
        check("rerun_pc", dut.pc, 32'd32);

        dut.imem[0] = enc_i(7, 0, 0, 0, 7'h13);
        pulse_reset();
        run_edges(1);
        check("x0_write", dut.regfile[0], 32'd0);
        check("x0_pc", dut.pc, 32'd4);

        dut.imem[0] = enc_i(5, 0, 0, 1, 7'h13);
        dut.imem[1] = enc_i(-1, 0, 0, 7, 7'h13);
        dut.imem[2] = enc_r(0, 1, 7, 5, 8);
        dut.imem[3] = enc_r(0, 0, 7, 2, 9);
        dut.imem[4] = enc_i(1, 0, 0, 10, 7'h13);
        dut.imem[5] = enc_r(0, 10, 7, 0, 11);
        dut.imem[6] = enc_j(0, 0);
        pulse_reset();
        run_edges(8);
        check("alu_x7", dut.regfile[7], 32'hFFFFFFFF);
        check("alu_srl", dut.regfile[8], 32'h07FFFFFF);
        check("alu_slt", dut.regfile[9], 32'd1);
        check("alu_wrap", dut.regfile[11], 32'd0);
        check("alu_pc", dut.pc, 32'd24);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 64; i++) begin
                m_imem[i] = rand_instr();
                dut.imem[i] = m_imem[i];
            end
            pulse_reset();
            for (int c = 0; c < 60; c++) begin
                @(posedge clk);
                model_step(rd);
                #1;
                check($sformatf("rnd%0d_pc", t), dut.pc, m_pc);
                check($sformatf("rnd%0d_x%0d", t, rd), dut.regfile[rd], m_x[rd]);
            end
            for (int i = 0; i < 32; i++) check($sformatf("rnd%0d_end_x%0d", t, i), dut.regfile[i], m_x[i]);
            for (int i = 0; i < 64; i++) check($sformatf("rnd%0d_end_mem%0d", t, i), dut.dmem[i], m_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
